// File: rtl/sync_down_counter_pkg.sv
// Shared constants for the synchronous down counter: FSM state encoding and default width.
package sync_down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/sync_down_counter_tff.sv
// tff_ld: one counter bit, a T flip-flop with parallel load.
// Priority is synchronous active-low reset, then load, then toggle.
module tff_ld (
    input  logic clk,
    input  logic reset_n,
    input  logic T,
    input  logic ld,
    input  logic d,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= 1'b0;
        end else if (ld) begin
            q_q <= d;
        end else if (T) begin
            q_q <= ~q_q;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/sync_down_counter.sv
// Loadable down counter built from T flip-flops, with an IDLE/RUN/DONE control FSM.
// Define SYNC_DOWN_COUNTER_AUTORELOAD_EN to reload the start value on reaching zero.
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] Q_ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic             cnt_en;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] t;

`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= load_val;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        cnt_en  = 1'b0;
        ld      = load;
        ld_val  = load_val;
        if (load) begin
            state_d = (load_val != '0) ? RUN : DONE;
        end else if (state_q == RUN && en) begin
            if (Q == Q_ONE) begin
                cnt_en = 1'b1;
                done_d = 1'b1;
`ifndef SYNC_DOWN_COUNTER_AUTORELOAD_EN
                state_d = DONE;
`endif
            end else if (Q == '0) begin
`ifdef SYNC_DOWN_COUNTER_AUTORELOAD_EN
                ld     = 1'b1;
                ld_val = reload_q;
`endif
            end else begin
                cnt_en = 1'b1;
            end
        end
    end

    // Borrow chain: a bit toggles when every lower bit is zero.
    always_comb begin
        t    = '0;
        t[0] = cnt_en;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] & ~Q[i-1];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_ld u_tff (
            .clk    (clk),
            .reset_n(reset_n),
            .T      (t[i]),
            .ld     (ld),
            .d      (ld_val[i]),
            .q      (Q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule
